// File: rtl/backscatter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : backscatter_pkg
// Brief    : Shared types and constants for the backscatter frame scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package backscatter_pkg;

    // Scheduler states, in the order a frame walks through them
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        DATA  = 3'd2,
        TAIL  = 3'd3,
        GUARD = 3'd4
    } sched_state_t;

    // Default preamble pattern, transmitted MSB first
    localparam logic [7:0] c_PREAMBLE_DEFAULT = 8'hA7;

    // Cycles from the accept edge to the frame_done pulse of an unaborted frame
    function automatic int unsigned frame_len(
        input int unsigned pre_w,
        input int unsigned data_w,
        input int unsigned bit_cycles,
        input int unsigned guard_cycles
    );
        return (pre_w + data_w + 1) * bit_cycles + guard_cycles + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fm0_bit_encoder.sv
`default_nettype none
// ============================================================================
// Module   : fm0_bit_encoder
// Brief    : FM0 level keeper. Inverts at each bit start, inverts again at
//            mid-bit for a '0'. The level survives between frames; only the
//            registered output is forced low when the line must be quiet.
// Revision : 1.0 - initial release
// ============================================================================
module fm0_bit_encoder (
    input  logic clk,
    input  logic rst,
    input  logic i_bit,
    input  logic i_bit_start,
    input  logic i_mid,
    input  logic i_force_low,
    output logic o_mod_out
);

    logic r_level;
    logic r_mod;
    logic w_level_nxt;

    // Next FM0 level: boundary inversion always, mid inversion only for '0'
    always_comb begin
        w_level_nxt = r_level;
        if (i_bit_start) begin
            w_level_nxt = ~r_level;
        end else if (i_mid && !i_bit) begin
            w_level_nxt = ~r_level;
        end
    end

    // Level and output registers; force_low masks the output, not the level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= 1'b0;
            r_mod   <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_mod   <= i_force_low ? 1'b0 : w_level_nxt;
        end
    end

    assign o_mod_out = r_mod;

endmodule
`default_nettype wire

// File: rtl/backscatter_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : backscatter_frame_sched
// Brief    : Frame scheduler for the backscatter modulator. Accepts a payload
//            word, sends preamble + payload (MSB first) + a '1' tail bit in
//            FM0, then holds the antenna line low for a guard interval.
// Revision : 1.0 - initial release
// ============================================================================
module backscatter_frame_sched
    import backscatter_pkg::*;
#(
    parameter int unsigned       DATA_W       = 16,
    parameter int unsigned       BIT_CYCLES   = 100,
    parameter int unsigned       PRE_W        = 8,
    parameter logic [PRE_W-1:0]  PREAMBLE     = PRE_W'(c_PREAMBLE_DEFAULT),
    parameter int unsigned       GUARD_CYCLES = 50
) (
    input  logic              clk,
    input  logic              rst_n,      // active-high synchronous reset
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic              abort,
    output logic              mod_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned c_CYC_W = $clog2(BIT_CYCLES);
    localparam int unsigned c_BIT_W = $clog2((PRE_W > DATA_W) ? PRE_W : DATA_W) + 1;
    localparam int unsigned c_GRD_W = $clog2(GUARD_CYCLES + 1);

    localparam logic [c_CYC_W-1:0] c_CYC_LAST  = c_CYC_W'(BIT_CYCLES - 1);
    localparam logic [c_CYC_W-1:0] c_CYC_MID   = c_CYC_W'(BIT_CYCLES / 2);
    localparam logic [c_BIT_W-1:0] c_PRE_LAST  = c_BIT_W'(PRE_W - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST = c_BIT_W'(DATA_W - 1);
    // Guard state holds one extra cycle so that the line is visibly low for
    // GUARD_CYCLES cycles after the registered tail bit.
    localparam logic [c_GRD_W-1:0] c_GRD_LAST  = c_GRD_W'(GUARD_CYCLES);

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;
    logic [c_CYC_W-1:0]   r_cyc_cnt;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [c_GRD_W-1:0]   r_guard_cnt;
    logic [DATA_W-1:0]    r_shift;
    logic [PRE_W-1:0]     r_pre;
    logic                 r_frame_done;
    logic                 w_accept;
    logic                 w_active;
    logic                 w_cyc_last;
    logic                 w_bit;

    assign w_active   = (r_state == PRE) || (r_state == DATA) || (r_state == TAIL);
    assign w_cyc_last = (r_cyc_cnt == c_CYC_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake outputs; abort beats a same-cycle request
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid && !abort) begin
                    w_accept    = 1'b1;
                    w_state_nxt = PRE;
                end
            end
            PRE: begin
                if (abort) begin
                    w_state_nxt = GUARD;
                end else if (w_cyc_last && (r_bit_cnt == c_PRE_LAST)) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (abort) begin
                    w_state_nxt = GUARD;
                end else if (w_cyc_last && (r_bit_cnt == c_DATA_LAST)) begin
                    w_state_nxt = TAIL;
                end
            end
            TAIL: begin
                if (abort || w_cyc_last) begin
                    w_state_nxt = GUARD;
                end
            end
            GUARD: begin
                if (r_guard_cnt == c_GRD_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bit timing counters, payload/preamble shift registers and guard timer
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_cyc_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_guard_cnt  <= '0;
            r_shift      <= '0;
            r_pre        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= (r_state == GUARD) && (r_guard_cnt == c_GRD_LAST);

            if ((r_state == GUARD) && (r_guard_cnt != c_GRD_LAST)) begin
                r_guard_cnt <= r_guard_cnt + c_GRD_W'(1);
            end else begin
                r_guard_cnt <= '0;
            end

            if (w_accept) begin
                r_shift   <= req_data;
                r_pre     <= PREAMBLE;
                r_cyc_cnt <= '0;
                r_bit_cnt <= '0;
            end else if (w_active && !abort) begin
                if (w_cyc_last) begin
                    r_cyc_cnt <= '0;
                    r_bit_cnt <= (w_state_nxt != r_state) ? '0 : r_bit_cnt + c_BIT_W'(1);
                    if (r_state == PRE) begin
                        r_pre <= {r_pre[PRE_W-2:0], 1'b0};
                    end
                    if (r_state == DATA) begin
                        r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    r_cyc_cnt <= r_cyc_cnt + c_CYC_W'(1);
                end
            end else begin
                r_cyc_cnt <= '0;
                r_bit_cnt <= '0;
            end
        end
    end

    // Bit currently on air
    always_comb begin
        w_bit = 1'b1;
        case (r_state)
            PRE:     w_bit = r_pre[PRE_W-1];
            DATA:    w_bit = r_shift[DATA_W-1];
            default: w_bit = 1'b1;
        endcase
    end

    // An abort silences the line on the same edge it is sampled
    fm0_bit_encoder u_fm0 (
        .clk         (clk),
        .rst         (rst_n),
        .i_bit       (w_bit),
        .i_bit_start (w_active && !abort && (r_cyc_cnt == '0)),
        .i_mid       (w_active && !abort && (r_cyc_cnt == c_CYC_MID)),
        .i_force_low (!w_active || abort),
        .o_mod_out   (mod_out)
    );

    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
